// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
// Covers the FSM state encoding, AXI burst constants and MIPS-style segment decoding.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_AR,
    MISS_R,
    REFILL,
    UNC_AR,
    UNC_R,
    RESP
  } state_e;

  localparam logic [2:0]  AXI_SIZE_WORD  = 3'd2;
  localparam logic [7:0]  AXI_LEN_SINGLE = 8'd0;

  localparam logic [2:0]  SEG_KSEG0 = 3'b100;
  localparam logic [2:0]  SEG_KSEG1 = 3'b101;
  localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else passes through.
  function automatic logic [31:0] virt_to_phys(input logic [31:0] vaddr);
    if (vaddr[31:29] == SEG_KSEG0 || vaddr[31:29] == SEG_KSEG1) begin
      return vaddr & PHYS_MASK;
    end
    return vaddr;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Collects the beats of one cache-line burst and flags a burst whose rlast
// does not coincide with the final expected beat.
module icache_line_buf #(
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     beat_valid,
  input  logic [31:0]              beat_data,
  input  logic                     beat_last,
  output logic [32*LINE_WORDS-1:0] line,
  output logic                     full,
  output logic                     rlast_err
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      words_q [LINE_WORDS];
  logic             at_last;

  assign at_last   = (cnt_q == LAST_IDX);
  // The burst ends on the expected final beat or on an early rlast, whichever comes first.
  assign full      = beat_valid & (at_last | beat_last);
  assign rlast_err = beat_valid & (at_last ^ beat_last);

  always_comb begin
    line = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      line[32*i +: 32] = words_q[i];
    end
  end

  // NOTE: the line buffer is cleared by reset so no stale data from a previous
  // power-on state can ever be presented alongside a refill.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else if (clear) begin
      cnt_q <= '0;
    end else if (beat_valid) begin
      words_q[cnt_q] <= beat_data;
      cnt_q          <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache front-end: looks up cached fetches, refills a line over AXI
// on a miss, and performs single-beat AXI reads for uncached fetches.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int         LINE_WORDS = 8,
  parameter logic [2:0] UNC_SEG    = 3'b101
) (
  input  logic                     clk,
  input  logic                     resetn,

  input  logic                     cpu_req,
  input  logic [31:0]              cpu_addr,
  output logic                     cpu_addr_ok,
  output logic                     cpu_data_ok,
  output logic [31:0]              cpu_rdata,

  output logic                     cache_req,
  output logic [31:0]              cache_vaddr,
  input  logic                     cache_hit,
  input  logic [31:0]              cache_rdata,
  output logic                     refill_valid,
  output logic [31:0]              refill_paddr,
  output logic [32*LINE_WORDS-1:0] refill_line,

  output logic                     axi_arvalid,
  input  logic                     axi_arready,
  output logic [31:0]              axi_araddr,
  output logic [7:0]               axi_arlen,
  output logic [2:0]               axi_arsize,
  input  logic                     axi_rvalid,
  output logic                     axi_rready,
  input  logic [31:0]              axi_rdata,
  input  logic                     axi_rlast,
  input  logic [1:0]               axi_rresp,

  output logic                     err,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
);

  localparam int OFF_W = $clog2(LINE_WORDS) + 2;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  logic                     accept;
  logic                     accept_unc;
  logic [31:0]              paddr;
  logic [31:0]              line_paddr;
  logic [OFF_W-3:0]         word_sel;
  logic                     line_beat;
  logic [32*LINE_WORDS-1:0] line;
  logic                     line_full;
  logic                     line_rlast_err;
  logic                     r_hs;

  assign cpu_addr_ok = (state_q == IDLE);
  assign accept      = cpu_req & cpu_addr_ok;
  assign accept_unc  = (cpu_addr[31:29] == UNC_SEG);

  assign paddr      = virt_to_phys(addr_q);
  assign line_paddr = {paddr[31:OFF_W], {OFF_W{1'b0}}};
  assign word_sel   = paddr[OFF_W-1:2];

  // The lookup strobe is issued in the accept cycle so the array answers in LOOKUP.
  assign cache_req   = accept & ~accept_unc;
  assign cache_vaddr = cpu_addr;

  assign axi_arvalid = (state_q == MISS_AR) | (state_q == UNC_AR);
  assign axi_araddr  = (state_q == MISS_AR) ? line_paddr : paddr;
  assign axi_arlen   = (state_q == UNC_AR) ? AXI_LEN_SINGLE : 8'(LINE_WORDS - 1);
  assign axi_arsize  = AXI_SIZE_WORD;
  assign axi_rready  = (state_q == MISS_R) | (state_q == UNC_R);
  assign r_hs        = axi_rvalid & axi_rready;

  assign refill_valid = (state_q == REFILL);
  assign refill_paddr = line_paddr;
  assign refill_line  = line;

  assign cpu_data_ok = (state_q == RESP);
  assign cpu_rdata   = rdata_q;
  assign err         = err_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;

  assign line_beat = (state_q == MISS_R) & axi_rvalid;

  icache_line_buf #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (accept),
    .beat_valid (line_beat),
    .beat_data  (axi_rdata),
    .beat_last  (axi_rlast),
    .line       (line),
    .full       (line_full),
    .rlast_err  (line_rlast_err)
  );

  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = accept_unc ? UNC_AR : LOOKUP;
      LOOKUP:  state_d = cache_hit ? RESP : MISS_AR;
      MISS_AR: if (axi_arready) state_d = MISS_R;
      MISS_R:  if (line_full) state_d = REFILL;
      REFILL:  state_d = RESP;
      UNC_AR:  if (axi_arready) state_d = UNC_R;
      UNC_R:   if (axi_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) addr_q <= cpu_addr;

      if (state_q == LOOKUP) begin
        if (cache_hit) begin
          rdata_q <= cache_rdata;
          if (hit_q != '1) hit_q <= hit_q + 32'd1;
        end else if (miss_q != '1) begin
          miss_q <= miss_q + 32'd1;
        end
      end

      if (state_q == REFILL) rdata_q <= line[32*int'(word_sel) +: 32];
      if (state_q == UNC_R && axi_rvalid) rdata_q <= axi_rdata;

      // Bus errors and malformed bursts are sticky until reset.
      if ((r_hs && axi_rresp != 2'b00) || line_rlast_err) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: an 8-word and a 4-word instance share
// stimulus, and only one of them is out of reset at a time.
module tb_icache_refill_ctrl;

  logic        clk;
  logic        rst8_n, rst4_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        axi_arready, axi_rvalid, axi_rlast;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;

  logic        addr_ok_a, data_ok_a, cache_req_a, refill_valid_a, arvalid_a, rready_a, err_a;
  logic [31:0] rdata_a, cache_vaddr_a, refill_paddr_a, araddr_a, hit_cnt_a, miss_cnt_a;
  logic [7:0]  arlen_a;
  logic [2:0]  arsize_a;
  logic [255:0] refill_line_a;

  logic        addr_ok_b, data_ok_b, cache_req_b, refill_valid_b, arvalid_b, rready_b, err_b;
  logic [31:0] rdata_b, cache_vaddr_b, refill_paddr_b, araddr_b, hit_cnt_b, miss_cnt_b;
  logic [7:0]  arlen_b;
  logic [2:0]  arsize_b;
  logic [127:0] refill_line_b;

  int n_checks = 0;
  int n_err    = 0;
  int refill_seen = 0;

  icache_refill_ctrl #(.LINE_WORDS(8)) dut_a (
    .clk(clk), .resetn(rst8_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_addr_ok(addr_ok_a),
    .cpu_data_ok(data_ok_a), .cpu_rdata(rdata_a),
    .cache_req(cache_req_a), .cache_vaddr(cache_vaddr_a), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .refill_valid(refill_valid_a),
    .refill_paddr(refill_paddr_a), .refill_line(refill_line_a),
    .axi_arvalid(arvalid_a), .axi_arready(axi_arready), .axi_araddr(araddr_a),
    .axi_arlen(arlen_a), .axi_arsize(arsize_a), .axi_rvalid(axi_rvalid),
    .axi_rready(rready_a), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .axi_rresp(axi_rresp),
    .err(err_a), .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a)
  );

  icache_refill_ctrl #(.LINE_WORDS(4)) dut_b (
    .clk(clk), .resetn(rst4_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_addr_ok(addr_ok_b),
    .cpu_data_ok(data_ok_b), .cpu_rdata(rdata_b),
    .cache_req(cache_req_b), .cache_vaddr(cache_vaddr_b), .cache_hit(cache_hit),
    .cache_rdata(cache_rdata), .refill_valid(refill_valid_b),
    .refill_paddr(refill_paddr_b), .refill_line(refill_line_b),
    .axi_arvalid(arvalid_b), .axi_arready(axi_arready), .axi_araddr(araddr_b),
    .axi_arlen(arlen_b), .axi_arsize(arsize_b), .axi_rvalid(axi_rvalid),
    .axi_rready(rready_b), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .axi_rresp(axi_rresp),
    .err(err_b), .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (refill_valid_a || refill_valid_b) refill_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a cached fetch, let it be accepted, and leave the FSM in MISS_AR.
  task automatic start_miss(input logic [31:0] addr);
    cpu_req   = 1'b1;
    cpu_addr  = addr;
    cache_hit = 1'b0;
    step();
    cpu_req = 1'b0;
    step();
  endtask

  task automatic send_beats(input logic [31:0] base, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      axi_rvalid = 1'b1;
      axi_rdata  = base + 32'(i);
      axi_rlast  = (i == last_at);
      step();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
  endtask

  initial begin
    logic stable;
    int   refill_before;

    rst8_n = 1'b0; rst4_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cache_hit = 1'b0; cache_rdata = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    axi_rdata = '0; axi_rresp = 2'b00;
    repeat (2) step();

    check("rst_arvalid",  arvalid_a,      1'b0);
    check("rst_rready",   rready_a,       1'b0);
    check("rst_refill",   refill_valid_a, 1'b0);
    check("rst_data_ok",  data_ok_a,      1'b0);
    check("rst_err",      err_a,          1'b0);
    check("rst_hit_cnt",  hit_cnt_a,      32'd0);
    check("rst_miss_cnt", miss_cnt_a,     32'd0);
    check("rst_rdata",    rdata_a,        32'd0);

    rst8_n = 1'b1;
    step();
    check("idle_addr_ok", addr_ok_a, 1'b1);
    axi_rvalid = 1'b1;
    #1 check("idle_rvalid_ignored", rready_a, 1'b0);
    axi_rvalid = 1'b0;
    step();

    // Cached hit at 0x8000_0104.
    cpu_req = 1'b1; cpu_addr = 32'h8000_0104;
    cache_hit = 1'b1; cache_rdata = 32'h1234_5678;
    #1;
    check("hit_cache_req",   cache_req_a,   1'b1);
    check("hit_cache_vaddr", cache_vaddr_a, 32'h8000_0104);
    step();
    cpu_addr = 32'h8000_0800;
    #1;
    check("busy_addr_ok",   addr_ok_a,   1'b0);
    check("busy_cache_req", cache_req_a, 1'b0);
    check("hit_lookup_no_ok", data_ok_a, 1'b0);
    cpu_req = 1'b0;
    step();
    check("hit_data_ok", data_ok_a,  1'b1);
    check("hit_rdata",   rdata_a,    32'h1234_5678);
    check("hit_cnt_1",   hit_cnt_a,  32'd1);
    check("hit_miss_0",  miss_cnt_a, 32'd0);
    cache_hit = 1'b0;
    step();
    check("hit_ok_pulse", data_ok_a, 1'b0);
    check("hit_rdata_hold", rdata_a, 32'h1234_5678);

    // Miss at 0x8000_0114: line 0x100, selected word 5.
    start_miss(32'h8000_0114);
    check("miss_arvalid", arvalid_a,  1'b1);
    check("miss_araddr",  araddr_a,   32'h0000_0100);
    check("miss_arlen",   arlen_a,    8'd7);
    check("miss_arsize",  arsize_a,   3'd2);
    check("miss_cnt_1",   miss_cnt_a, 32'd1);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    #1;
    check("miss_single_ar", arvalid_a, 1'b0);
    check("miss_rready",    rready_a,  1'b1);
    send_beats(32'hA0, 8, 7);
    check("miss_refill_valid", refill_valid_a, 1'b1);
    check("miss_refill_paddr", refill_paddr_a, 32'h0000_0100);
    check("miss_line_word3",   refill_line_a[3*32 +: 32], 32'hA3);
    check("miss_no_err",       err_a, 1'b0);
    step();
    check("miss_data_ok",  data_ok_a,      1'b1);
    check("miss_rdata",    rdata_a,        32'hA5);
    check("miss_refill_1", refill_valid_a, 1'b0);
    step();

    // Uncached fetch at 0xBFC0_0000.
    cpu_req = 1'b1; cpu_addr = 32'hBFC0_0000;
    #1 check("unc_no_cache_req", cache_req_a, 1'b0);
    step();
    cpu_req = 1'b0;
    #1;
    check("unc_arvalid", arvalid_a, 1'b1);
    check("unc_araddr",  araddr_a,  32'h1FC0_0000);
    check("unc_arlen",   arlen_a,   8'd0);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    check("unc_rready", rready_a, 1'b1);
    send_beats(32'hDEAD_BEEF, 1, 0);
    check("unc_data_ok",  data_ok_a,  1'b1);
    check("unc_rdata",    rdata_a,    32'hDEAD_BEEF);
    check("unc_hit_cnt",  hit_cnt_a,  32'd1);
    check("unc_miss_cnt", miss_cnt_a, 32'd1);
    check("unc_no_err",   err_a,      1'b0);
    step();

    // Uncached read with a SLVERR response: data still returned, err sticks.
    cpu_req = 1'b1; cpu_addr = 32'hA000_0040;
    step();
    cpu_req = 1'b0;
    check("rresp_araddr", araddr_a, 32'h0000_0040);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    axi_rresp = 2'b10;
    send_beats(32'h0000_55AA, 1, 0);
    axi_rresp = 2'b00;
    check("rresp_data_ok", data_ok_a, 1'b1);
    check("rresp_rdata",   rdata_a,   32'h0000_55AA);
    check("rresp_err",     err_a,     1'b1);
    step();

    // Asynchronous reset in mid-cycle clears status immediately.
    #2 rst8_n = 1'b0;
    #1;
    check("areset_err",      err_a,      1'b0);
    check("areset_hit_cnt",  hit_cnt_a,  32'd0);
    check("areset_miss_cnt", miss_cnt_a, 32'd0);
    check("areset_rdata",    rdata_a,    32'd0);
    step();
    rst8_n = 1'b1;
    step();

    // AR held off for 5 cycles, then an early rlast on beat 3.
    start_miss(32'h8000_0200);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(arvalid_a === 1'b1 && araddr_a === 32'h200 && arlen_a === 8'd7 && arsize_a === 3'd2))
        stable = 1'b0;
      step();
    end
    check("ar_stable", stable, 1'b1);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    send_beats(32'hB0, 4, 3);
    check("early_last_refill", refill_valid_a, 1'b1);
    check("early_last_err",    err_a,          1'b1);
    step();
    check("early_last_data_ok", data_ok_a, 1'b1);
    check("early_last_rdata",   rdata_a,   32'hB0);
    step();

    // Reset in the middle of a burst abandons it.
    start_miss(32'h8000_0300);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    send_beats(32'hE0, 4, -1);
    refill_before = refill_seen;
    axi_rvalid = 1'b1; axi_rdata = 32'hE4;
    #2 rst8_n = 1'b0;
    #1;
    check("midreset_rready",  rready_a,  1'b0);
    check("midreset_addr_ok", addr_ok_a, 1'b1);
    step();
    rst8_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rready_a !== 1'b0) stable = 1'b0;
    end
    axi_rvalid = 1'b0;
    check("midreset_beats_ignored", stable, 1'b1);
    check("midreset_no_refill", 32'(refill_seen), 32'(refill_before));
    cpu_req = 1'b1; cpu_addr = 32'h8000_0008;
    cache_hit = 1'b1; cache_rdata = 32'h0BAD_F00D;
    step();
    cpu_req = 1'b0;
    step();
    cache_hit = 1'b0;
    check("post_reset_data_ok", data_ok_a, 1'b1);
    check("post_reset_rdata",   rdata_a,   32'h0BAD_F00D);
    check("post_reset_hit_cnt", hit_cnt_a, 32'd1);
    step();

    // Four-word line: miss at 0x8000_001C selects beat 3 of line 0x10.
    rst8_n = 1'b0;
    rst4_n = 1'b1;
    step();
    start_miss(32'h8000_001C);
    check("lw4_araddr", araddr_b, 32'h0000_0010);
    check("lw4_arlen",  arlen_b,  8'd3);
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    send_beats(32'hC0, 4, 3);
    check("lw4_refill_valid", refill_valid_b, 1'b1);
    check("lw4_refill_paddr", refill_paddr_b, 32'h0000_0010);
    check("lw4_no_err",       err_b,          1'b0);
    step();
    check("lw4_data_ok", data_ok_b, 1'b1);
    check("lw4_rdata",   rdata_b,   32'hC3);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per cache line; power of two, 2..16.
REQ-002 SHALL have parameter UNC_SEG, default 3'b101, value of addr[31:29] marking an uncached access.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port resetn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have CPU ports:
- cpu_req, in, 1
- cpu_addr, in, 32, virtual fetch address
- cpu_addr_ok, out, 1, request accepted
- cpu_data_ok, out, 1, rdata valid
- cpu_rdata, out, 32
REQ-006 SHALL have cache-array ports:
- cache_req, out, 1, lookup strobe
- cache_vaddr, out, 32
- cache_hit, in, 1, valid in LOOKUP
- cache_rdata, in, 32, valid in LOOKUP
- refill_valid, out, 1
- refill_paddr, out, 32, line-aligned
- refill_line, out, 32*LINE_WORDS, word 0 in the LSBs
REQ-007 SHALL have AXI read ports:
- axi_arvalid, out, 1
- axi_arready, in, 1
- axi_araddr, out, 32
- axi_arlen, out, 8
- axi_arsize, out, 3
- axi_rvalid, in, 1
- axi_rready, out, 1
- axi_rdata, in, 32
- axi_rlast, in, 1
- axi_rresp, in, 2
REQ-008 SHALL have status ports:
- err, out, 1, sticky bus/protocol error
- hit_cnt, out, 32, saturating
- miss_cnt, out, 32, saturating

Function
REQ-009 SHALL use states IDLE, LOOKUP, MISS_AR, MISS_R, REFILL, UNC_AR, UNC_R, RESP.
REQ-010 SHALL drive cpu_addr_ok=1 exactly when state==IDLE; accept = cpu_req & cpu_addr_ok; on accept, latch cpu_addr.
REQ-011 SHALL compute paddr = vaddr & 32'h1FFF_FFFF when vaddr[31:29] is 3'b100 or 3'b101; otherwise paddr = vaddr.
REQ-012 SHALL classify an access as uncached iff cpu_addr[31:29]==UNC_SEG.
- Uncached accept: go to UNC_AR.
- Cached accept: drive cache_req=1 and cache_vaddr=cpu_addr combinationally in the accept cycle, then go to LOOKUP.
REQ-013 In LOOKUP, SHALL latch cache_rdata on cache_hit=1, increment hit_cnt and go to RESP; otherwise increment miss_cnt and go to MISS_AR.
REQ-014 In MISS_AR, SHALL drive:
- axi_arvalid=1
- axi_araddr = paddr with bits [log2(LINE_WORDS)+1:0] cleared
- axi_arlen = LINE_WORDS-1
- axi_arsize=3'd2
These SHALL stay stable until axi_arready; on arready, go to MISS_R.
REQ-015 In MISS_R, SHALL drive axi_rready=1 and store each beat at index beat_cnt, then increment beat_cnt.
- Beat with beat_cnt==LINE_WORDS-1: go to REFILL.
- axi_rlast on an earlier beat: go to REFILL and set err.
- axi_rlast absent on the final beat: go to REFILL and set err.
REQ-016 In REFILL, SHALL pulse refill_valid for one cycle with refill_line and refill_paddr, select word paddr[log2(LINE_WORDS)+1:2] into the response register, then go to RESP.
REQ-017 For uncached accesses:
- UNC_AR SHALL drive araddr=paddr, arlen=0, arsize=2, and move to UNC_R on arready.
- UNC_R SHALL drive rready=1, capture rdata on rvalid, and then go to RESP.
REQ-018 In RESP, SHALL drive cpu_data_ok=1 for one cycle with cpu_rdata, then return to IDLE; cpu_rdata SHALL hold its value until the next RESP.
REQ-019 Latency from accept to cpu_data_ok: a hit SHALL take 2 cycles; a miss SHALL take the AR wait plus LINE_WORDS beats plus 2 cycles; an uncached access SHALL take cpu_data_ok 1 cycle after the R beat.
REQ-020 Any beat with axi_rresp != 0 SHALL set err; the data is still used and the transaction completes normally.
REQ-021 hit_cnt and miss_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-022 cpu_req while not in IDLE SHALL be ignored and SHALL NOT be latched; the CPU holds the request.
REQ-023 axi_rvalid outside MISS_R/UNC_R SHALL be ignored, with axi_rready=0.

Reset
REQ-024 resetn low SHALL immediately (asynchronously) force:
- state=IDLE and beat_cnt=0
- err, hit_cnt, miss_cnt, cpu_rdata, the line buffer and latched address = 0
- all strobes 0: arvalid, rready, refill_valid, cpu_data_ok, cache_req
REQ-025 Reset mid-burst SHALL abandon the transaction without asserting refill_valid; beats after release SHALL be ignored per REQ-023.

Structure
REQ-026 Package icache_pkg SHALL hold the state enum, the AXI size/len constants, the kseg0/kseg1 segment constants and the physical mask 32'h1FFF_FFFF.
REQ-027 SHALL instantiate one sub-module icache_line_buf (parameter LINE_WORDS) owning the beat counter and the line buffer, with outputs line, full, rlast_err.

Verification
REQ-028 With LINE_WORDS=8, a cached hit at 0x8000_0104 (cache_hit=1, cache_rdata=0x1234_5678) SHALL give cpu_data_ok 2 cycles after accept with rdata 0x1234_5678 and hit_cnt=1.
REQ-029 A miss at 0x8000_0114 SHALL issue a single AR with araddr=0x0000_0100 and arlen=7; beats 0..7 = 0xA0..0xA7 SHALL give refill_paddr=0x100 and cpu_rdata=0xA5.
REQ-030 An uncached access at 0xBFC0_0000 SHALL issue araddr=0x1FC0_0000 and arlen=0; beat 0xDEAD_BEEF SHALL give cpu_data_ok the next cycle with that data; hit_cnt and miss_cnt SHALL be unchanged.
REQ-031 With arready held low 5 cycles, araddr, arlen and arsize SHALL stay stable; with rlast on beat 3 of 8, err SHALL be set and refill_valid SHALL pulse.
REQ-032 resetn low after beat 4 SHALL immediately drop rready and return to IDLE, with no refill_valid; a next hit SHALL complete normally.
REQ-033 With LINE_WORDS=4 and a miss at 0x8000_001C, SHALL issue araddr=0x10 and arlen=3, and the selected word SHALL be beat 3.
